button_conditioner: RTL and testbench



---
 rtl/button_conditioner.sv | 130 +++++++++++++
 tb/tb_button_conditioner.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// N-channel push-button front end: two-flop synchroniser, debounce filter, one-cycle press pulse.
// Define BUTTON_AUTOREPEAT_EN to re-issue press pulses while a button stays held.
module button_conditioner #(
  parameter int N               = 4,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic [N-1:0] bi,
  output logic [N-1:0] bo,
  output logic [N-1:0] level
);

  localparam int             CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, PRESS, HELD} state_t;

  if (N < 1 || DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_bad_param
    $error("button_conditioner: parameter out of range");
  end

  logic [N-1:0] s1, s2;

  // NOTE: non-blocking assignments so every flop samples its pre-edge inputs.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= bi;
      s2 <= s1;
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_ch
    logic [CW-1:0] cnt;
    logic          level_q, bo_q, bo_nxt;
    logic          accept, rise, fall;
    state_t        state, state_nxt;

    assign accept   = (s2[g] != level_q) && (cnt == CNT_LAST);
    assign rise     = accept &  s2[g];
    assign fall     = accept & ~s2[g];
    assign level[g] = level_q;
    assign bo[g]    = bo_q;

    // Any edge where the synchronised input agrees with level restarts the count.
    always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
        cnt     <= '0;
        level_q <= 1'b0;
      end else if (s2[g] == level_q) begin
        cnt     <= '0;
      end else if (cnt == CNT_LAST) begin
        level_q <= s2[g];
        cnt     <= '0;
      end else begin
        cnt     <= cnt + 1'b1;
      end
    end

`ifdef BUTTON_AUTOREPEAT_EN
    localparam int            RMAX   = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int            RW     = $clog2(RMAX);
    localparam logic [RW-1:0] R_DLY  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] R_PER  = RW'(REPEAT_PERIOD - 1);
    logic [RW-1:0] rcnt, rcnt_nxt;
`endif

    // NOTE: every output of this block gets a default first, so no latch is inferred.
    always_comb begin
      state_nxt = state;
      bo_nxt    = 1'b0;
`ifdef BUTTON_AUTOREPEAT_EN
      rcnt_nxt  = rcnt;
`endif
      case (state)
        IDLE: begin
          if (rise) begin
            state_nxt = PRESS;
            bo_nxt    = 1'b1;
`ifdef BUTTON_AUTOREPEAT_EN
            rcnt_nxt  = R_DLY;
`endif
          end
        end
        PRESS, HELD: begin
          if (fall) begin
            state_nxt = IDLE;
`ifdef BUTTON_AUTOREPEAT_EN
            rcnt_nxt  = '0;
`endif
          end else begin
            state_nxt = HELD;
`ifdef BUTTON_AUTOREPEAT_EN
            // Down-counter reaching zero marks the edge a repeat pulse is due.
            if (rcnt == '0) begin
              bo_nxt   = 1'b1;
              rcnt_nxt = R_PER;
            end else begin
              rcnt_nxt = rcnt - 1'b1;
            end
`endif
          end
        end
        default: state_nxt = IDLE;
      endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
        state <= IDLE;
        bo_q  <= 1'b0;
`ifdef BUTTON_AUTOREPEAT_EN
        rcnt  <= '0;
`endif
      end else begin
        state <= state_nxt;
        bo_q  <= bo_nxt;
`ifdef BUTTON_AUTOREPEAT_EN
        rcnt  <= rcnt_nxt;
`endif
      end
    end
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner: a queue-based reference model predicts level/bo
// after every clock edge; a monitor pops and compares. Directed cases plus random stimulus.
module tb_button_conditioner;

  localparam int N  = 4;
  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RP = 5;

  logic         Clk = 1'b0;
  logic         Rst = 1'b1;
  logic [N-1:0] bi  = '0;
  logic [N-1:0] bo, level;

  int checks   = 0;
  int failures = 0;

  button_conditioner #(
    .N(N), .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .Clk(Clk), .Rst(Rst), .bi(bi), .bo(bo), .level(level)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [N-1:0] level;
    logic [N-1:0] bo;
  } exp_t;

  exp_t exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a level flips once the last DB values seen by the debouncer (raw input
  // delayed two edges) all disagree with it; a press pulse marks each 0->1 flip.
  bit seen_q[N][$];
  bit win_q[N][$];
  bit m_level[N];
  int press_at[N];
  int edge_n = 0;

  initial begin
    exp_t e;
    bit   vis, old, all_diff;
    int   el;
    forever begin
      @(posedge Clk);
      edge_n++;
      e = '0;
      if (Rst) begin
        for (int c = 0; c < N; c++) begin
          seen_q[c].delete();
          win_q[c].delete();
          m_level[c] = 1'b0;
        end
      end else begin
        for (int c = 0; c < N; c++) begin
          vis = 1'b0;
          seen_q[c].push_back(bi[c]);
          if (seen_q[c].size() > 2) vis = seen_q[c].pop_front();
          win_q[c].push_back(vis);
          if (win_q[c].size() > DB) void'(win_q[c].pop_front());
          old      = m_level[c];
          all_diff = (win_q[c].size() == DB);
          for (int i = 0; i < win_q[c].size(); i++)
            if (win_q[c][i] == old) all_diff = 1'b0;
          if (all_diff) m_level[c] = !old;
          if (!old && m_level[c]) begin
            e.bo[c]     = 1'b1;
            press_at[c] = edge_n;
          end
`ifdef BUTTON_AUTOREPEAT_EN
          else if (old && m_level[c]) begin
            el = edge_n - press_at[c];
            if (el >= RD && (el - RD) % RP == 0) e.bo[c] = 1'b1;
          end
`endif
          e.level[c] = m_level[c];
        end
      end
      exp_q.push_back(e);
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(posedge Clk);
      #1;
      if (exp_q.size() == 0) begin
        check("scoreboard empty", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("level", 64'(level), 64'(e.level));
        check("bo", 64'(bo), 64'(e.bo));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic wait_level(input int ch, input logic val, output int edges);
    edges = 0;
    do begin
      @(posedge Clk);
      #1;
      edges++;
    end while (level[ch] !== val && edges < 40);
  endtask

  task automatic async_reset();
    @(posedge Clk);
    #3 Rst = 1'b1;
    #1;
    check("reset level", 64'(level), 64'd0);
    check("reset bo", 64'(bo), 64'd0);
    @(negedge Clk);
    @(negedge Clk);
    Rst = 1'b0;
  endtask

  int lat;
  int run_left[N];
  int pulses;

  initial begin
    tick(3);
    check("reset level", 64'(level), 64'd0);
    check("reset bo", 64'(bo), 64'd0);
    Rst = 1'b0;
    tick(3);

    // Single press: level and bo rise together DB+2 edges after first sampling edge.
    bi[0] = 1'b1;
    wait_level(0, 1'b1, lat);
    check("press latency ch0", 64'(lat), 64'(DB + 2));
    check("press pulse ch0", 64'(bo), 64'b0001);
    @(posedge Clk);
    #1;
    check("pulse width ch0", 64'(bo[0]), 64'd0);
    tick(5);

    // Three-cycle glitch is rejected.
    bi[1] = 1'b1;
    tick(3);
    bi[1] = 1'b0;
    tick(12);
    check("glitch level ch1", 64'(level[1]), 64'd0);

    // Hold then release: release latency matches press latency, no release pulse.
    bi[2] = 1'b1;
    tick(20);
    bi[2] = 1'b0;
    wait_level(2, 1'b0, lat);
    check("release latency ch2", 64'(lat), 64'(DB + 2));
    check("release bo ch2", 64'(bo[2]), 64'd0);
    tick(3);

    // Simultaneous presses give pulses in the same cycle.
    bi[0] = 1'b0;
    tick(10);
    bi = 4'b1001;
    wait_level(0, 1'b1, lat);
    check("simultaneous bo", 64'(bo), 64'b1001);
    tick(5);
    bi = '0;
    tick(10);

    // Async reset while ch1 held and ch2 mid-debounce; held ch1 reports a fresh press.
    bi[1] = 1'b1;
    tick(10);
    check("ch1 held before reset", 64'(level[1]), 64'd1);
    bi[2] = 1'b1;
    repeat (3) @(posedge Clk);
    async_reset();
    wait_level(1, 1'b1, lat);
    check("press after reset ch1", 64'(lat), 64'(DB + 2));
    check("pulse after reset ch1", 64'(bo[1]), 64'd1);
    tick(2);
    bi = '0;
    tick(12);

`ifdef BUTTON_AUTOREPEAT_EN
    // Held button repeats RD edges after the press, then every RP edges.
    bi[0] = 1'b1;
    wait_level(0, 1'b1, lat);
    check("repeat press pulse", 64'(bo[0]), 64'd1);
    pulses = 0;
    for (int i = 1; i <= 25; i++) begin
      @(posedge Clk);
      #1;
      if (bo[0]) begin
        pulses++;
        check("repeat pulse offset", 64'(((i - RD) % RP == 0 && i >= RD) ? 1 : 0), 64'd1);
      end
    end
    check("repeat pulse count", 64'(pulses), 64'd4);
    @(negedge Clk);
    bi[0] = 1'b0;
    tick(20);
`endif

    // Random stimulus: per-channel runs of 1..8 cycles, one async reset halfway.
    for (int c = 0; c < N; c++) run_left[c] = 0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      if (cyc == 400) async_reset();
      @(negedge Clk);
      for (int c = 0; c < N; c++) begin
        if (run_left[c] == 0) begin
          bi[c]       = 1'($urandom_range(0, 1));
          run_left[c] = int'($urandom_range(1, 8));
        end
        run_left[c]--;
      end
    end
    bi = '0;
    tick(12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
